// File: rtl/nibble_serial_adder.sv
// Serial adder: one 4-bit slice per clock, NIB run cycles per operation.
// Add mode sums a+b+cin; accumulate mode sums acc+b+cin and writes the result back to acc.
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic             clr_acc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [WIDTH-1:0] acc,
   output logic             busy,
   output logic             done
);

   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] r_sum;
   logic [WIDTH-1:0] r_acc;
   logic [IDXW-1:0]  r_idx;
   logic             r_carry;
   logic             r_mode;
   logic             r_cout;
   logic             r_ovf;

   logic [3:0]       w_x_nib;
   logic [3:0]       w_y_nib;
   logic [4:0]       w_slice;
   logic [WIDTH-1:0] w_result;
   logic             w_last;

   assign w_x_nib = 4'(r_x >> {r_idx, 2'b00});
   assign w_y_nib = 4'(r_y >> {r_idx, 2'b00});
   assign w_slice = {1'b0, w_x_nib} + {1'b0, w_y_nib} + {4'b0000, r_carry};
   assign w_last  = (r_idx == IDXW'(NIB - 1));

   // Working result with the current slice merged in, so DONE can capture the final nibble on the same edge.
   generate
      for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
         assign w_result[4*gi +: 4] = (r_idx == IDXW'(gi)) ? w_slice[3:0] : r_work[4*gi +: 4];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_work  <= '0;
         r_sum   <= '0;
         r_acc   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_mode  <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (clr_acc) begin
                  r_acc <= '0;
               end
               if (start) begin
                  r_x     <= mode ? (clr_acc ? '0 : r_acc) : a;
                  r_y     <= b;
                  r_carry <= cin;
                  r_mode  <= mode;
                  r_idx   <= '0;
                  r_work  <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_work  <= w_result;
               r_carry <= w_slice[4];
               r_idx   <= r_idx + 1'b1;
               if (w_last) begin
                  r_state <= S_DONE;
                  r_sum   <= w_result;
                  r_cout  <= w_slice[4];
                  r_ovf   <= (r_x[WIDTH-1] == r_y[WIDTH-1]) && (w_result[WIDTH-1] != r_x[WIDTH-1]);
                  if (r_mode) begin
                     r_acc <= w_result;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;
   assign acc  = r_acc;
   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 16-bit instance for the main checks
// and a 4-bit instance for the single-slice case.
module tb_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic        clr_acc = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic [15:0] acc;
   logic        busy;
   logic        done;

   logic        start4 = 1'b0;
   logic        mode4 = 1'b0;
   logic        clr4 = 1'b0;
   logic [3:0]  a4 = '0;
   logic [3:0]  b4 = '0;
   logic        cin4 = 1'b0;
   logic [3:0]  sum4;
   logic        cout4;
   logic        ovf4;
   logic [3:0]  acc4;
   logic        busy4;
   logic        done4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .clr_acc(clr_acc),
      .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout), .ovf(ovf),
      .acc(acc), .busy(busy), .done(done)
   );

   nibble_serial_adder #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .mode(mode4), .clr_acc(clr4),
      .a(a4), .b(b4), .cin(cin4), .sum(sum4), .cout(cout4), .ovf(ovf4),
      .acc(acc4), .busy(busy4), .done(done4)
   );

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for done; returns the number of edges waited.
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic do_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic icin, input logic imode, input logic iclr);
      int n;
      a = ia; b = ib; cin = icin; mode = imode; clr_acc = iclr; start = 1'b1;
      tick();
      start = 1'b0; clr_acc = 1'b0;
      wait_done(n);
      chk({tag, "_lat"}, n, 4);
      $display("op %s a=%h b=%h cin=%0d mode=%0d -> sum=%h cout=%0d ovf=%0d acc=%h",
               tag, ia, ib, icin, imode, sum, cout, ovf, acc);
      tick();
   endtask

   initial begin
      int n;
      int last;
      int pulses;

      // Reset state
      tick(); tick(); tick();
      chk("rst_sum", sum, 0);
      chk("rst_acc", acc, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      tick();

      // Basic add with cycle-exact latency
      a = 16'h0004; b = 16'h000F; cin = 1'b0; mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("add_busy_e0", busy, 1);
      chk("add_done_e0", done, 0);
      for (int e = 1; e <= 3; e++) begin
         tick();
         chk("add_done_early", done, 0);
      end
      tick();
      chk("add_done_e4", done, 1);
      chk("add_sum", sum, 16'h0013);
      chk("add_cout", cout, 0);
      chk("add_ovf", ovf, 0);
      $display("op add a=0004 b=000f -> sum=%h cout=%0d ovf=%0d", sum, cout, ovf);
      tick();
      chk("add_done_e5", done, 0);
      chk("add_busy_e5", busy, 0);

      // Boundaries
      do_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      chk("wrap_sum", sum, 16'h0000);
      chk("wrap_cout", cout, 1);
      chk("wrap_ovf", ovf, 0);
      do_op("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      chk("posovf_sum", sum, 16'h8000);
      chk("posovf_cout", cout, 0);
      chk("posovf_ovf", ovf, 1);
      do_op("negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
      chk("negovf_sum", sum, 16'h0000);
      chk("negovf_cout", cout, 1);
      chk("negovf_ovf", ovf, 1);
      do_op("chain", 16'h1234, 16'h0FFF, 1'b1, 1'b0, 1'b0);
      chk("chain_sum", sum, 16'h2234);
      chk("chain_acc_mode0", acc, 0);

      // Accumulate 0..15, cin=0 then cin=1
      clr_acc = 1'b1;
      tick();
      clr_acc = 1'b0;
      chk("clr_acc", acc, 0);
      for (int i = 0; i < 16; i++) do_op("acc0", 16'hDEAD, 16'(i), 1'b0, 1'b1, 1'b0);
      chk("acc0_acc", acc, 16'h0078);
      chk("acc0_sum", sum, 16'h0078);
      clr_acc = 1'b1;
      tick();
      clr_acc = 1'b0;
      chk("clr_acc2", acc, 0);
      for (int i = 0; i < 16; i++) do_op("acc1", 16'hBEEF, 16'(i), 1'b1, 1'b1, 1'b0);
      chk("acc1_acc", acc, 16'h0088);

      // Inputs changed mid-operation are ignored
      a = 16'h1234; b = 16'h1111; cin = 1'b0; mode = 1'b0; start = 1'b1;
      tick();
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; mode = 1'b1; clr_acc = 1'b1;
      tick();
      tick();
      start = 1'b0; clr_acc = 1'b0; mode = 1'b0;
      wait_done(n);
      chk("ign_lat", n, 2);
      chk("ign_sum", sum, 16'h2345);
      chk("ign_acc", acc, 16'h0088);
      $display("op ignore a=1234 b=1111 -> sum=%h acc=%h", sum, acc);
      tick();

      // clr_acc together with start in accumulate mode uses X=0
      do_op("clrstart", 16'h0000, 16'h0005, 1'b0, 1'b1, 1'b1);
      chk("clrstart_sum", sum, 16'h0005);
      chk("clrstart_acc", acc, 16'h0005);

      // start held high: done every 6 cycles
      a = 16'h0001; b = 16'h0001; cin = 1'b0; mode = 1'b0; start = 1'b1;
      last = -1;
      pulses = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (done === 1'b1) begin
            if (last >= 0) chk("held_gap", k - last, 6);
            last = k;
            pulses++;
         end
      end
      start = 1'b0;
      $display("op held start -> pulses=%0d sum=%h", pulses, sum);
      chk("held_pulses", pulses, 5);
      chk("held_sum", sum, 16'h0002);
      n = 0;
      while (busy !== 1'b0 && n < 10) begin
         tick();
         n++;
      end
      chk("held_idle", busy, 0);

      // Reset mid-RUN of an accumulate, then an immediate add
      a = 16'h0000; b = 16'h0003; mode = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("abort_sum", sum, 0);
      chk("abort_acc", acc, 0);
      chk("abort_cout", cout, 0);
      chk("abort_ovf", ovf, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      rst = 1'b0;
      a = 16'h0001; b = 16'h0002; mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("post_busy", busy, 1);
      for (int e = 0; e < 3; e++) begin
         tick();
         chk("post_no_done", done, 0);
      end
      tick();
      chk("post_done", done, 1);
      chk("post_sum", sum, 16'h0003);
      chk("post_acc", acc, 0);
      $display("op post-reset a=0001 b=0002 -> sum=%h", sum);
      tick();

      // WIDTH=4 instance
      a4 = 4'h4; b4 = 4'hF; cin4 = 1'b1; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      chk("w4_busy", busy4, 1);
      tick();
      chk("w4_done", done4, 1);
      chk("w4_sum", sum4, 4'h4);
      chk("w4_cout", cout4, 1);
      chk("w4_ovf", ovf4, 0);
      $display("op w4 a=4 b=f cin=1 -> sum=%h cout=%0d ovf=%0d", sum4, cout4, ovf4);
      tick();
      chk("w4_done_end", done4, 0);
      chk("w4_busy_end", busy4, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; SHALL be a multiple of 4 and >= 4.
REQ-002 Derived constant NIB = WIDTH/4: the number of 4-bit slices, which is also the number of RUN cycles.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: request an operation; sampled only in IDLE.
REQ-006 Port mode, input, 1: 0 = add (a+b+cin); 1 = accumulate (acc+b+cin).
REQ-007 Port clr_acc, input, 1: clear the accumulator; sampled only in IDLE.
REQ-008 Ports a and b, input, WIDTH each: operands; a is unused when mode=1.
REQ-009 Port cin, input, 1: carry into slice 0.
REQ-010 Port sum, output, WIDTH: registered result.
REQ-011 Port cout, output, 1: carry out of the last slice.
REQ-012 Port ovf, output, 1: two's-complement overflow of the last result.
REQ-013 Port acc, output, WIDTH: accumulator register value.
REQ-014 Port busy, output, 1: high in RUN and DONE.
REQ-015 Port done, output, 1: single-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE; IDLE->RUN on start; RUN->DONE after slice NIB-1; DONE->IDLE unconditionally.
REQ-017 On the start edge the block SHALL latch:
- X = a (mode=0) or acc (mode=1)
- Y = b
- carry = cin
- mode
- slice index = 0
REQ-018 Each RUN cycle SHALL compute one slice, {c,s} = X[4i+3:4i] + Y[4i+3:4i] + carry, write s into working nibble i, set carry <= c and increment i.
REQ-019 Slice arithmetic SHALL use a 4-bit add with carry only, with no full-WIDTH adder.
REQ-020 Latency: with start sampled at edge 0, slices are computed on edges 1..NIB and done SHALL be high for exactly the cycle following edge NIB.
REQ-021 On entering DONE the block SHALL update:
- sum = working result
- cout = final carry
- ovf = (X[MSB]==Y[MSB]) && (result[MSB]!=X[MSB])
REQ-022 sum, cout and ovf SHALL hold until the next DONE entry.
REQ-023 The result SHALL wrap modulo 2^WIDTH.
REQ-024 If the latched mode=1, acc SHALL be loaded with the result on the same edge; in mode 0, acc SHALL be unchanged.
REQ-025 start, clr_acc, a, b, cin and mode SHALL be ignored while busy=1; operands SHALL not be re-sampled mid-operation.
REQ-026 clr_acc in IDLE without start SHALL set acc to 0 on the next edge.
REQ-027 clr_acc and start together in IDLE with mode=1 SHALL use X = 0 and start the operation; acc SHALL then take the result at DONE.
REQ-028 If start is held high, a new operation SHALL be accepted on every IDLE cycle, giving a throughput of one operation per NIB+2 cycles.

Reset
REQ-029 While rst is high at an edge, the block SHALL force:
- state = IDLE
- sum = acc = 0
- cout = ovf = busy = done = 0
- working registers and slice index = 0
REQ-030 rst SHALL take priority over start and clr_acc.
REQ-031 rst asserted mid-RUN SHALL abort the operation with no DONE and no acc update; a start in the first cycle after rst deasserts SHALL be accepted normally.

Verification (WIDTH=16 unless stated)
REQ-032 Add: a=0x0004, b=0x000F, cin=0, mode=0 -> sum=0x0013, cout=0, ovf=0; done high only in the cycle after edge 4; busy low after edge 5.
REQ-033 Boundaries:
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1
REQ-034 Accumulate:
- clr_acc, then 16 mode=1 operations with b=0..15 and cin=0 -> acc=sum=0x0078
- repeat with cin=1 -> acc=0x0088
REQ-035 Protocol:
- start pulsed in RUN with different a/b -> ignored; the result matches the original operands
- start held high -> done pulses every 6 cycles
REQ-036 Reset: rst at edge 2 of a mode=1 operation -> all outputs 0 and no done pulse; a following add with a=0x0001, b=0x0002 -> sum=0x0003.
REQ-037 WIDTH=4 instance: a=0x4, b=0xF, cin=1 -> sum=0x4, cout=1, ovf=0; done in the cycle after edge 1.
